// File: rtl/board_pkg.sv
// Shared definitions for the board conditioning block: default sizes,
// default cycle constants, the reset FSM state type and a counter-width helper.
package board_pkg;

    localparam int KEYS_W_DEF          = 2;
    localparam int LEDS_W_DEF          = 6;
    localparam int SYNC_STAGES_DEF     = 2;
    localparam int DEBOUNCE_CYCLES_DEF = 270000;
    localparam int RST_STRETCH_DEF     = 16;
    localparam int REPEAT_DELAY_DEF    = 13500000;
    localparam int REPEAT_PERIOD_DEF   = 2700000;

    typedef enum logic [1:0] {
        HOLD    = 2'd0,
        STRETCH = 2'd1,
        RUN     = 2'd2
    } rst_state_t;

    // Bits needed to hold values 0..max_val (at least one bit).
    function automatic int cnt_width(input int max_val);
        if (max_val < 1) begin
            return 1;
        end else begin
            return $clog2(max_val + 1);
        end
    endfunction

endpackage

// File: rtl/board_io_cond_if.sv
// Pin-side bundle of board_io_cond: PLL lock, keys and LEDs in, conditioned
// reset / key events / LED pins out. The DUT uses the slave modport.
interface board_io_cond_if import board_pkg::*; #(
    parameter int N_KEYS = KEYS_W_DEF,
    parameter int LEDS_W = LEDS_W_DEF
);
    logic              pll_lock_i;
    logic [N_KEYS-1:0] keys_raw_i;
    logic [LEDS_W-1:0] leds_i;
    logic [LEDS_W-1:0] leds_o;
    logic              rst_o;
    logic [N_KEYS-1:0] keys_o;
    logic [N_KEYS-1:0] keys_pressed_o;
    logic [N_KEYS-1:0] keys_released_o;

    modport master (
        output pll_lock_i, keys_raw_i, leds_i,
        input  leds_o, rst_o, keys_o, keys_pressed_o, keys_released_o
    );

    modport slave (
        input  pll_lock_i, keys_raw_i, leds_i,
        output leds_o, rst_o, keys_o, keys_pressed_o, keys_released_o
    );
endinterface

// File: rtl/io_key_debounce.sv
// One key channel: polarity fix, synchroniser, debounce filter and one-cycle
// press/release pulses. Auto-repeat press pulses exist only when
// BOARD_IO_KEY_AUTOREPEAT_EN is defined.
module io_key_debounce import board_pkg::*; #(
    parameter int KEY_ACTIVE_LOW  = 1,
    parameter int SYNC_STAGES     = SYNC_STAGES_DEF,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
`ifdef BOARD_IO_KEY_AUTOREPEAT_EN
    ,
    parameter int REPEAT_DELAY    = REPEAT_DELAY_DEF,
    parameter int REPEAT_PERIOD   = REPEAT_PERIOD_DEF
`endif
) (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic sync_rst_i,
    input  logic key_raw_i,
    output logic key_o,
    output logic pressed_o,
    output logic released_o
);
    localparam int   SS      = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;
    localparam int   DB      = (DEBOUNCE_CYCLES < 1) ? 1 : DEBOUNCE_CYCLES;
    localparam int   CW      = cnt_width(DB);
    localparam logic KEY_INV = (KEY_ACTIVE_LOW != 0) ? 1'b1 : 1'b0;

    logic [SS-1:0] sync_q;
    logic          k_s;
    logic          stable_q, stable_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          pressed_q, pressed_d;
    logic          released_q, released_d;

    assign k_s = sync_q[SS-1];

    // Synchroniser chain; the sample is already converted to 1 = pressed.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SS-2:0], key_raw_i ^ KEY_INV};
        end
    end

`ifdef BOARD_IO_KEY_AUTOREPEAT_EN
    localparam int RD = (REPEAT_DELAY < 1) ? 1 : REPEAT_DELAY;
    localparam int RP = (REPEAT_PERIOD < 1) ? 1 : REPEAT_PERIOD;
    localparam int RW = cnt_width((RD > RP) ? RD : RP);

    logic [RW-1:0] rpt_q, rpt_d;
    logic          armed_q, armed_d;
`endif

    // Debounce filter: accept a new level after DB consecutive differing samples.
    always_comb begin
        stable_d   = stable_q;
        cnt_d      = cnt_q;
        pressed_d  = 1'b0;
        released_d = 1'b0;
        if (sync_rst_i) begin
            stable_d = 1'b0;
            cnt_d    = '0;
        end else if (k_s == stable_q) begin
            cnt_d = '0;
        end else if (cnt_q >= CW'(DB - 1)) begin
            stable_d   = k_s;
            cnt_d      = '0;
            pressed_d  = k_s;
            released_d = ~k_s;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
`ifdef BOARD_IO_KEY_AUTOREPEAT_EN
        // Repeat timer: first extra press after RD held cycles, then every RP.
        rpt_d   = rpt_q;
        armed_d = armed_q;
        if (sync_rst_i || !stable_q || !stable_d) begin
            rpt_d   = '0;
            armed_d = 1'b0;
        end else if (!armed_q) begin
            if (rpt_q >= RW'(RD - 1)) begin
                pressed_d = 1'b1;
                rpt_d     = '0;
                armed_d   = 1'b1;
            end else begin
                rpt_d = rpt_q + RW'(1);
            end
        end else if (rpt_q >= RW'(RP - 1)) begin
            pressed_d = 1'b1;
            rpt_d     = '0;
        end else begin
            rpt_d = rpt_q + RW'(1);
        end
`endif
    end

    // Debounce state and registered event pulses.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            stable_q   <= 1'b0;
            cnt_q      <= '0;
            pressed_q  <= 1'b0;
            released_q <= 1'b0;
        end else begin
            stable_q   <= stable_d;
            cnt_q      <= cnt_d;
            pressed_q  <= pressed_d;
            released_q <= released_d;
        end
    end

`ifdef BOARD_IO_KEY_AUTOREPEAT_EN
    // Auto-repeat timer state.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            rpt_q   <= '0;
            armed_q <= 1'b0;
        end else begin
            rpt_q   <= rpt_d;
            armed_q <= armed_d;
        end
    end
`endif

    assign key_o      = stable_q;
    assign pressed_o  = pressed_q;
    assign released_o = released_q;

endmodule

// File: rtl/board_io_cond.sv
// Board conditioning top: clean system reset from board reset + PLL lock,
// N debounced keys with press/release pulses, polarity-corrected LED pins.
// Optional macro: BOARD_IO_KEY_AUTOREPEAT_EN enables key auto-repeat.
module board_io_cond import board_pkg::*; #(
    parameter int N_KEYS             = KEYS_W_DEF,
    parameter int KEY_ACTIVE_LOW     = 1,
    parameter int LEDS_W             = LEDS_W_DEF,
    parameter int LED_ACTIVE_LOW     = 1,
    parameter int SYNC_STAGES        = SYNC_STAGES_DEF,
    parameter int DEBOUNCE_CYCLES    = DEBOUNCE_CYCLES_DEF,
    parameter int RST_STRETCH_CYCLES = RST_STRETCH_DEF
`ifdef BOARD_IO_KEY_AUTOREPEAT_EN
    ,
    parameter int REPEAT_DELAY       = REPEAT_DELAY_DEF,
    parameter int REPEAT_PERIOD      = REPEAT_PERIOD_DEF
`endif
) (
    input  logic            clk_i,
    input  logic            rst_n_i,
    board_io_cond_if.slave  bus
);
    localparam int   SS      = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;
    localparam int   RS      = (RST_STRETCH_CYCLES < 1) ? 1 : RST_STRETCH_CYCLES;
    localparam int   SW      = cnt_width(RS);
    localparam logic LED_INV = (LED_ACTIVE_LOW != 0) ? 1'b1 : 1'b0;

    logic [SS-1:0]     lock_sync_q;
    logic              lock_s;
    rst_state_t        state_q;
    logic [SW-1:0]     stretch_q;
    logic              rst_q;
    logic [LEDS_W-1:0] leds_q;
    logic [N_KEYS-1:0] keys_s;
    logic [N_KEYS-1:0] pressed_s;
    logic [N_KEYS-1:0] released_s;

    assign lock_s = lock_sync_q[SS-1];

    // PLL lock synchroniser.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            lock_sync_q <= '0;
        end else begin
            lock_sync_q <= {lock_sync_q[SS-2:0], bus.pll_lock_i};
        end
    end

    // Reset sequencer: hold until lock, stretch RS cycles, run; lock loss re-holds.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q   <= HOLD;
            stretch_q <= '0;
            rst_q     <= 1'b1;
        end else begin
            case (state_q)
                HOLD: begin
                    stretch_q <= '0;
                    rst_q     <= 1'b1;
                    if (lock_s) begin
                        state_q <= STRETCH;
                    end else begin
                        state_q <= HOLD;
                    end
                end
                STRETCH: begin
                    if (!lock_s) begin
                        state_q   <= HOLD;
                        stretch_q <= '0;
                        rst_q     <= 1'b1;
                    end else if (stretch_q >= SW'(RS - 1)) begin
                        state_q   <= RUN;
                        stretch_q <= '0;
                        rst_q     <= 1'b0;
                    end else begin
                        stretch_q <= stretch_q + SW'(1);
                        rst_q     <= 1'b1;
                    end
                end
                RUN: begin
                    stretch_q <= '0;
                    if (!lock_s) begin
                        state_q <= HOLD;
                        rst_q   <= 1'b1;
                    end else begin
                        rst_q   <= 1'b0;
                    end
                end
                default: begin
                    state_q   <= HOLD;
                    stretch_q <= '0;
                    rst_q     <= 1'b1;
                end
            endcase
        end
    end

    // LED pins: board polarity, one register stage, independent of rst_o.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            leds_q <= {LEDS_W{LED_INV}};
        end else begin
            leds_q <= bus.leds_i ^ {LEDS_W{LED_INV}};
        end
    end

    for (genvar g = 0; g < N_KEYS; g++) begin : g_key
        io_key_debounce #(
            .KEY_ACTIVE_LOW  (KEY_ACTIVE_LOW),
            .SYNC_STAGES     (SS),
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
`ifdef BOARD_IO_KEY_AUTOREPEAT_EN
            ,
            .REPEAT_DELAY    (REPEAT_DELAY),
            .REPEAT_PERIOD   (REPEAT_PERIOD)
`endif
        ) u_key (
            .clk_i      (clk_i),
            .rst_n_i    (rst_n_i),
            .sync_rst_i (rst_q),
            .key_raw_i  (bus.keys_raw_i[g]),
            .key_o      (keys_s[g]),
            .pressed_o  (pressed_s[g]),
            .released_o (released_s[g])
        );
    end

    assign bus.rst_o           = rst_q;
    assign bus.leds_o          = leds_q;
    assign bus.keys_o          = keys_s;
    assign bus.keys_pressed_o  = pressed_s;
    assign bus.keys_released_o = released_s;

endmodule
